// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: write-pointer synchronizer,
// Gray/binary read pointer, empty and level flags, and a registered valid/ready output stage.
module fifo_rd_ctrl #(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 8
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [Addr_Width:0]   wr_ptr_gray,
  input  logic [Data_Width-1:0] mem_data,
  output logic [Addr_Width:0]   rd_addr,
  output logic [Addr_Width:0]   rd_ptr_gray,
  output logic                  empty,
  output logic [Addr_Width:0]   rd_level,
  output logic [Data_Width-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PW = Addr_Width + 1;

  logic [PW-1:0]         wq1_reg, wq2_reg, wq2_bin;
  logic [PW-1:0]         rd_bin_reg, rd_bin_next;
  logic [PW-1:0]         rd_gray_reg, rd_gray_next;
  logic [PW-1:0]         rd_bin_inc;
  logic [Data_Width-1:0] dout_reg, dout_next;
  logic                  dout_valid_reg, dout_valid_next;
  logic                  empty_int;
  logic                  pop;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign wq2_bin[gi] = ^wq2_reg[PW-1:gi];
    end
  endgenerate

  // Empty compares registered values only, so it can lag but never lie.
  assign empty_int  = (rd_gray_reg == wq2_reg);
  assign rd_bin_inc = rd_bin_reg + PW'(1);
  assign pop        = !empty_int && (!dout_valid_reg || dout_ready);

  always_comb begin
    rd_bin_next     = rd_bin_reg;
    rd_gray_next    = rd_gray_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    if (pop) begin
      rd_bin_next     = rd_bin_inc;
      rd_gray_next    = rd_bin_inc ^ (rd_bin_inc >> 1);
      dout_next       = mem_data;
      dout_valid_next = 1'b1;
    end else if (dout_valid_reg && dout_ready) begin
      dout_valid_next = 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wq1_reg        <= '0;
      wq2_reg        <= '0;
      rd_bin_reg     <= '0;
      rd_gray_reg    <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      wq1_reg        <= wr_ptr_gray;
      wq2_reg        <= wq1_reg;
      rd_bin_reg     <= rd_bin_next;
      rd_gray_reg    <= rd_gray_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

  assign rd_addr     = rd_bin_reg;
  assign rd_ptr_gray = rd_gray_reg;
  assign empty       = empty_int;
  assign rd_level    = wq2_bin - rd_bin_reg;
  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a 256-word memory model driven by the DUT read address,
// write pointer stepped by hand, immediate assertions on hand-computed values.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] wr_ptr_gray;
  logic [7:0] mem_data;
  logic [8:0] rd_addr;
  logic [8:0] rd_ptr_gray;
  logic       empty;
  logic [8:0] rd_level;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  logic [7:0] mem [256];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[rd_addr[7:0]];

  fifo_rd_ctrl #(.Data_Width(8), .Addr_Width(8)) dut (
    .rd_clk      (clk),
    .rd_rst      (rst),
    .wr_ptr_gray (wr_ptr_gray),
    .mem_data    (mem_data),
    .rd_addr     (rd_addr),
    .rd_ptr_gray (rd_ptr_gray),
    .empty       (empty),
    .rd_level    (rd_level),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
  );

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: got %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 29) ^ 8'hC5;
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;

    // Reset held two cycles with a write pointer already showing 6 words.
    rst = 1'b1; wr_ptr_gray = 9'h005; dout_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("rst_empty", empty, 1);
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_gray", rd_ptr_gray, 0);
    end
    rst = 1'b0;
    tick();
    chk("rel1_empty", empty, 1);
    chk("rel1_valid", dout_valid, 0);
    tick();
    chk("rel2_empty", empty, 0);
    chk("rel2_valid", dout_valid, 0);
    chk("rel2_level", rd_level, 6);
    tick();
    chk("rel3_valid", dout_valid, 1);
    chk("rel3_dout", dout, 8'hA1);
    chk("rel3_addr", rd_addr, 1);
    chk("rel3_gray", rd_ptr_gray, 1);
    for (int h = 0; h < 2; h++) begin
      tick();
      chk("hold_dout", dout, 8'hA1);
      chk("hold_addr", rd_addr, 1);
      chk("hold_level", rd_level, 5);
    end

    // Reset while a word is held: word discarded, pointers cleared, no pop.
    rst = 1'b1; wr_ptr_gray = 9'h000;
    tick();
    chk("mid_valid", dout_valid, 0);
    chk("mid_addr", rd_addr, 0);
    chk("mid_gray", rd_ptr_gray, 0);
    chk("mid_dout", dout, 0);
    chk("mid_empty", empty, 1);
    rst = 1'b0;
    tick();
    tick();
    chk("post_valid", dout_valid, 0);
    chk("post_empty", empty, 1);

    // Basic latency: three words, consumer always ready.
    dout_ready = 1'b1; wr_ptr_gray = gray(9'd3);
    tick();
    chk("lat_n_empty", empty, 1);
    tick();
    chk("lat_n1_empty", empty, 0);
    chk("lat_n1_valid", dout_valid, 0);
    chk("lat_n1_level", rd_level, 3);
    tick();
    chk("lat_n2_dout", dout, 8'hA1);
    chk("lat_n2_valid", dout_valid, 1);
    chk("lat_n2_level", rd_level, 2);
    tick();
    chk("lat_n3_dout", dout, 8'hB2);
    tick();
    chk("lat_n4_dout", dout, 8'hC3);
    chk("lat_n4_empty", empty, 1);
    chk("lat_n4_level", rd_level, 0);
    tick();
    chk("lat_n5_valid", dout_valid, 0);
    chk("lat_n5_addr", rd_addr, 3);

    // Backpressure: four words at 3..6, stalled for five cycles.
    dout_ready = 1'b0; wr_ptr_gray = gray(9'd7);
    tick();
    tick();
    tick();
    chk("bp_first", dout, mem[3]);
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("bp_hold_dout", dout, mem[3]);
      chk("bp_hold_addr", rd_addr, 4);
      chk("bp_hold_valid", dout_valid, 1);
    end
    dout_ready = 1'b1;
    for (int w = 4; w < 7; w++) begin
      tick();
      chk("bp_rel_dout", dout, mem[w]);
      chk("bp_rel_valid", dout_valid, 1);
    end
    tick();
    chk("bp_drain_valid", dout_valid, 0);
    chk("bp_drain_empty", empty, 1);
    chk("bp_drain_addr", rd_addr, 7);

    // Level: a full memory (256 words) seen from rd_bin 0.
    rst = 1'b1; wr_ptr_gray = 9'h000; dout_ready = 1'b0;
    tick();
    rst = 1'b0; wr_ptr_gray = gray(9'd256);
    tick();
    tick();
    chk("lvl_full", rd_level, 256);
    chk("lvl_full_valid", dout_valid, 0);
    tick();
    chk("lvl_after_pop", rd_level, 255);
    chk("lvl_pop_dout", dout, 8'hA1);
    chk("lvl_pop_addr", rd_addr, 1);

    // Stream up to rd_bin 510, checking every word.
    wr_ptr_gray = gray(9'd510); dout_ready = 1'b1;
    k = 1;
    for (int c = 0; c < 700 && !(rd_addr == 9'd510 && !dout_valid); c++) begin
      tick();
      if (dout_valid) begin
        chk("stream_data", dout, mem[k[7:0]]);
        k++;
      end
    end
    chk("stream_count", k, 510);
    chk("stream_addr", rd_addr, 510);
    chk("stream_gray", rd_ptr_gray, 9'h101);
    chk("stream_empty", empty, 1);

    // Wrap: four more words (write pointer 514 mod 512 = 2).
    wr_ptr_gray = gray(9'd2);
    tick();
    chk("wrap_n_empty", empty, 1);
    tick();
    chk("wrap_n1_empty", empty, 0);
    chk("wrap_n1_level", rd_level, 4);
    tick();
    chk("wrap_d0", dout, mem[254]);
    chk("wrap_a0", rd_addr, 511);
    chk("wrap_g0", rd_ptr_gray, 9'h100);
    tick();
    chk("wrap_d1", dout, mem[255]);
    chk("wrap_a1", rd_addr, 0);
    chk("wrap_g1", rd_ptr_gray, 9'h000);
    chk("wrap_e1", empty, 0);
    chk("wrap_l1", rd_level, 2);
    tick();
    chk("wrap_d2", dout, mem[0]);
    chk("wrap_a2", rd_addr, 1);
    chk("wrap_g2", rd_ptr_gray, 9'h001);
    tick();
    chk("wrap_d3", dout, mem[1]);
    chk("wrap_e3", empty, 1);
    chk("wrap_l3", rd_level, 0);
    tick();
    chk("wrap_drain", dout_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
